// File: rtl/counter_cmd_seq_pkg.sv
// counter_seq_pkg: opcodes, FSM states, FIFO sizing and load-value clamp shared by counter_cmd_seq
package counter_seq_pkg;
  typedef enum logic [1:0] {OP_HOLD = 2'b00, OP_LOAD = 2'b01, OP_UP = 2'b10, OP_DOWN = 2'b11} op_e;
  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;
  localparam int FIFO_DEPTH = 4;
  localparam logic [3:0] MOD_MAX = 4'd11;
  typedef struct packed {
    op_e        op;
    logic [3:0] data;
    logic [3:0] len;
  } cmd_t;
  function automatic logic [3:0] clamp(input logic [3:0] d);
    return d > MOD_MAX ? MOD_MAX : d;
  endfunction
endpackage

// File: rtl/counter_cmd_seq_if.sv
// counter_cmd_seq_if: command handshake (cmd_valid/ready/op/data/len) and counter-control outputs
//   master: command producer / observer; slave: counter_cmd_seq
interface counter_cmd_seq_if;
  logic       cmd_valid, cmd_ready, load_in, up_down, busy, err;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data, cmd_len, data_in;
  modport master(output cmd_valid, cmd_op, cmd_data, cmd_len,
                 input cmd_ready, load_in, data_in, up_down, busy, err);
  modport slave(input cmd_valid, cmd_op, cmd_data, cmd_len,
                output cmd_ready, load_in, data_in, up_down, busy, err);
endinterface

// File: rtl/counter_cmd_fifo.sv
// counter_cmd_fifo: 4-entry command FIFO
//   clock, rst (sync, active-high); push/din write; pop advances head dout; full, empty, count status
module counter_cmd_fifo
  import counter_seq_pkg::*;
(
  input  logic       clock,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  cmd_t       din,
  output cmd_t       dout,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);
  cmd_t       mem [FIFO_DEPTH];
  logic [1:0] wr, rd;
  assign dout  = mem[rd];
  assign full  = count == 3'(FIFO_DEPTH);
  assign empty = count == 3'd0;
  always_ff @(posedge clock)
    if (push) mem[wr] <= din;
  always_ff @(posedge clock)
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 2'd1;
      if (pop) rd <= rd + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
endmodule

// File: rtl/counter_cmd_seq.sv
// counter_cmd_seq: queues HOLD/LOAD/UP/DOWN commands and sequences a mod-12 counter's controls
//   clock, rst (sync, active-high); bus (counter_cmd_seq_if.slave): cmd_* handshake in,
//   load_in/data_in/up_down/busy/err out.
//   Optional CNT_SEQ_RANGE_CHK_EN: clamp HOLD/LOAD data above 11 to 11 and set sticky err.
module counter_cmd_seq
  import counter_seq_pkg::*;
(
  input logic              clock,
  input logic              rst,
  counter_cmd_seq_if.slave bus
);
  state_e     state, state_nx;
  cmd_t       head;
  logic       full, empty, push, pop, last, is_ld, load_q, up_q;
  logic [2:0] count;
  logic [3:0] cnt, data_q, ld_data;
  assign push          = bus.cmd_valid & ~full;
  assign last          = state == EXEC && cnt == 4'd0;
  assign pop           = ~empty && (state == IDLE || last);
  assign is_ld         = head.op == OP_HOLD || head.op == OP_LOAD;
  assign bus.cmd_ready = count != 3'(FIFO_DEPTH);
  assign bus.busy      = state == EXEC || count != 3'd0;
  assign bus.load_in   = load_q;
  assign bus.data_in   = data_q;
  assign bus.up_down   = up_q;
  counter_cmd_fifo fifo (
    .clock(clock), .rst(rst), .push(push), .pop(pop),
    .din('{op: op_e'(bus.cmd_op), data: bus.cmd_data, len: bus.cmd_len}),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
`ifdef CNT_SEQ_RANGE_CHK_EN
  logic err_q;
  assign ld_data = clamp(head.data);
  assign bus.err = err_q;
  always_ff @(posedge clock)
    if (rst) err_q <= 1'b0;
    else if (pop && is_ld && head.data > MOD_MAX) err_q <= 1'b1;
`else
  assign ld_data = head.data;
  assign bus.err = 1'b0;
`endif
  always_ff @(posedge clock)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = pop ? EXEC : last ? IDLE : state;
  // Outputs only change on a pop or when the final command ends; otherwise they hold.
  always_ff @(posedge clock)
    if (rst) begin
      cnt    <= '0;
      load_q <= 1'b0;
      data_q <= '0;
      up_q   <= 1'b1;
    end else if (pop) begin
      cnt    <= head.op == OP_LOAD ? 4'd0 : head.len;
      load_q <= is_ld;
      if (is_ld) data_q <= ld_data;
      else up_q <= head.op == OP_UP;
    end else begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      if (last) load_q <= 1'b0;
    end
endmodule

// File: doc/counter_cmd_seq.md
COUNTER_CMD_SEQ -- requirements
Module: counter_cmd_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock, rst (rst sampled only on posedge clock).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command present on cmd_* this cycle.
REQ-005 SHALL have port cmd_ready  output  1  FIFO can accept a command; a transfer occurs when cmd_valid & cmd_ready at posedge.
REQ-006 SHALL have port cmd_op  input  2  opcode: 00 HOLD, 01 LOAD, 10 UP, 11 DOWN.
REQ-007 SHALL have port cmd_data  input  4  load value for HOLD/LOAD; ignored for UP/DOWN.
REQ-008 SHALL have port cmd_len  input  4  repeat count; command lasts cmd_len+1 cycles (LOAD is always 1 cycle).
REQ-009 SHALL have port load_in  output  1  load strobe to the mod-12 counter.
REQ-010 SHALL have port data_in  output  4  load value to the counter.
REQ-011 SHALL have port up_down  output  1  count direction, 1 = up.
REQ-012 SHALL have port busy  output  1  a command is executing or the FIFO is non-empty.
REQ-013 SHALL have port err  output  1  sticky range-error flag (see Configuration).

Function
REQ-014 SHALL buffer commands in a 4-entry FIFO; cmd_ready = !full, combinational from the FIFO count only.
REQ-015 SHALL use FSM states IDLE, EXEC; IDLE->EXEC on a pop, EXEC->EXEC on a pop in the last cycle of a command, EXEC->IDLE at the end of the last cycle when the FIFO is empty.
REQ-016 SHALL pop the FIFO head at a posedge when the FIFO is non-empty and the FSM is in IDLE or in the last cycle of a command; load_in/data_in/up_down are registered at that same edge.
REQ-017 SHALL give a latency of one cycle: a command accepted at edge N drives outputs from edge N+1 when the FIFO is empty and the FSM is in IDLE.
REQ-018 SHALL execute back-to-back commands with no idle cycle between them.
REQ-019 HOLD SHALL drive load_in=1 and data_in=cmd_data for cmd_len+1 cycles; up_down SHALL be unchanged.
REQ-020 LOAD SHALL drive load_in=1 and data_in=cmd_data for exactly 1 cycle; up_down SHALL be unchanged.
REQ-021 UP/DOWN SHALL drive load_in=0 and up_down=1/0 for cmd_len+1 cycles; data_in SHALL keep its last value.
REQ-022 The per-command cycle counter SHALL be 4 bits and count down from cmd_len to 0; 0 marks the last cycle.
REQ-023 In IDLE the block SHALL drive load_in=0 and hold up_down and data_in at their last values.
REQ-024 A push and a pop in the same cycle SHALL leave the FIFO count unchanged; a push while full cannot occur because cmd_ready is 0.
REQ-025 busy SHALL be 1 in EXEC or when the FIFO count is nonzero; otherwise 0.

Reset
REQ-026 rst SHALL force IDLE, empty the FIFO, and set the cycle counter to 0, load_in=0, data_in=0, up_down=1, busy=0, err=0, cmd_ready=1 after the edge.
REQ-027 rst asserted mid-command SHALL abort the command and discard all FIFO entries, with no further output activity.
REQ-028 A command presented together with rst SHALL be dropped.

Configuration
REQ-029 When CNT_SEQ_RANGE_CHK_EN is defined, a HOLD/LOAD with cmd_data>11 SHALL drive data_in=11 and set err, which stays set until rst.
REQ-030 When CNT_SEQ_RANGE_CHK_EN is not defined, cmd_data SHALL pass unmodified and err SHALL be tied to 0.

Structure
REQ-031 Package counter_seq_pkg SHALL hold the opcode enum, the FSM state enum, FIFO_DEPTH=4 and MOD_MAX=11.
REQ-032 The FIFO SHALL be the sub-module counter_cmd_fifo: 4 x 10-bit entries, with push/pop/full/empty/count signals.

Verification
REQ-033 After reset, push LOAD data=5 -> load_in=1, data_in=5 for one cycle, starting one cycle after acceptance; then busy=0.
REQ-034 Push UP len=3 then DOWN len=1 back-to-back -> up_down=1 for 4 cycles, then up_down=0 for 2 cycles, with no gap; load_in=0 throughout.
REQ-035 Push 5 commands while the first executes -> cmd_ready=0 after the 4th accepted entry, rises after the next pop; all 5 execute in order.
REQ-036 Assert rst during UP len=15 at cycle 6 -> outputs return to reset values, the FIFO is empty, and no queued command executes.
REQ-037 With CNT_SEQ_RANGE_CHK_EN, push LOAD data=14 -> data_in=11 and err=1 until rst; without the macro -> data_in=14 and err=0.
